payload_feeder: RTL

- Upstream stage of control_engine.
- Accepts the packet payload as a 64-bit stream (valid/ready, byte keep, last) and serialises it into the one-byte-per-cycle payload_in / payload_valid / start_of_packet / end_of_packet interface that control_engine consumes.
- Holds off the next packet until control_engine reports completion via its end_of_packet_shift pulse, so curPacketID and rule_id stay aligned with packets.
- Clamps packet length to the 11-bit index range used by the matcher.

---
 rtl/payload_feeder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/payload_feeder.sv
// payload_feeder: serialises a 64-bit keep/last stream into the one-byte-per-cycle
// payload interface of control_engine. It blocks the next packet until the engine
// reports completion, clamps packets to MAX_PKT_BYTES and counts empty packets.
module payload_feeder #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_PKT_BYTES = 2047,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [7:0]            payload_out,
  output logic                  payload_valid,
  output logic                  start_of_packet,
  output logic                  end_of_packet,
  input  logic                  engine_done,
  output logic [10:0]           pkt_len,
  output logic                  truncated,
  output logic [15:0]           drop_count
);

  localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, WAIT_DONE, GAP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                  last_q, last_d;
  logic                  started_q, started_d;
  logic [10:0]           pkt_len_q, pkt_len_d;
  logic                  truncated_q, truncated_d;
  logic [15:0]           drop_q, drop_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  live_q;

  logic [KEEP_WIDTH-1:0] rest_keep;
  logic [7:0]            cur_byte;
  logic [10:0]           len_base;
  logic                  has_byte, is_final, hit_max, emit, sop, eop;
  logic                  trunc_now, shift_rdy, accept, empty_drop;

  // Decode the held word: byte under the pointer, remaining keep bits and packet events.
  always_comb begin
    cur_byte = 8'd0;
    for (int i = KEEP_WIDTH - 1; i >= 0; i--) begin
      if (keep_q[i]) cur_byte = word_q[i*8 +: 8];
    end
    rest_keep  = keep_q & (keep_q - KEEP_WIDTH'(1));
    has_byte   = |keep_q;
    is_final   = (rest_keep == '0);
    len_base   = started_q ? pkt_len_q : 11'd0;
    hit_max    = has_byte && (len_base == 11'(MAX_PKT_BYTES - 1));
    emit       = (state_q == SHIFT) && has_byte;
    sop        = emit && !started_q;
    eop        = (state_q == SHIFT) &&
                 ((has_byte && ((is_final && last_q) || hit_max)) ||
                  (!has_byte && last_q && started_q));
    trunc_now  = emit && hit_max && !(is_final && last_q);
    shift_rdy  = (state_q == SHIFT) && is_final && !last_q && !hit_max;
    accept     = s_tvalid && s_tready;
    empty_drop = ((state_q == SHIFT) && !has_byte && last_q && !started_q) ||
                 ((state_q == IDLE) && accept && (s_tkeep == '0) && s_tlast && !started_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !empty_drop) state_d = SHIFT;
      end
      SHIFT: begin
        if (eop)             state_d = trunc_now ? DRAIN : WAIT_DONE;
        else if (empty_drop) state_d = IDLE;
        else if (shift_rdy)  state_d = s_tvalid ? SHIFT : IDLE;
      end
      DRAIN: begin
        if (accept && s_tlast) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (engine_done) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready only once reset has been released for a cycle.
  always_comb begin
    s_tready        = live_q && ((state_q == IDLE) || (state_q == DRAIN) || shift_rdy);
    payload_valid   = emit;
    payload_out     = emit ? cur_byte : 8'd0;
    start_of_packet = sop;
    end_of_packet   = eop;
    pkt_len         = pkt_len_q;
    truncated       = truncated_q;
    drop_count      = drop_q;
  end

  // Datapath and counter updates.
  always_comb begin
    word_d      = word_q;
    keep_d      = keep_q;
    last_d      = last_q;
    started_d   = started_q;
    pkt_len_d   = pkt_len_q;
    truncated_d = truncated_q;
    drop_d      = drop_q;
    gap_d       = gap_q;
    if (accept && (state_q != DRAIN)) begin
      word_d = s_tdata;
      keep_d = s_tkeep;
      last_d = s_tlast;
    end else if (emit) begin
      keep_d = rest_keep;
    end
    if (eop)       started_d = 1'b0;
    else if (emit) started_d = 1'b1;
    if (sop)       pkt_len_d = 11'd1;
    else if (emit) pkt_len_d = pkt_len_q + 11'd1;
    if (eop) truncated_d = trunc_now;
    if (empty_drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    if ((state_q == WAIT_DONE) && engine_done) gap_d = GAP_W'(GAP_CYCLES);
    else if (state_q == GAP)                   gap_d = gap_q - GAP_W'(1);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keep_q      <= '0;
      last_q      <= 1'b0;
      started_q   <= 1'b0;
      pkt_len_q   <= 11'd0;
      truncated_q <= 1'b0;
      drop_q      <= 16'd0;
      gap_q       <= '0;
      live_q      <= 1'b0;
    end else begin
      keep_q      <= keep_d;
      last_q      <= last_d;
      started_q   <= started_d;
      pkt_len_q   <= pkt_len_d;
      truncated_q <= truncated_d;
      drop_q      <= drop_d;
      gap_q       <= gap_d;
      live_q      <= 1'b1;
    end
  end

  // Held data word; only read while keep bits are live, so it needs no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule
